// File: rtl/led_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver:
// glyph patterns (active-low, a..g), special codes, FSM states.
package led_scan_driver_pkg;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_F     = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hC;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/led_scan_driver_seg7_decode.sv
// seg7_decode: 4-bit character code to active-low segments.
// Ports: i_code (code in), o_seg (segments, bit6=a .. bit0=g).
module seg7_decode
    import led_scan_driver_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0:      o_seg = SEG_0;
            4'h1:      o_seg = SEG_1;
            4'h2:      o_seg = SEG_2;
            4'h3:      o_seg = SEG_3;
            4'h4:      o_seg = SEG_4;
            4'h5:      o_seg = SEG_5;
            4'h6:      o_seg = SEG_6;
            4'h7:      o_seg = SEG_7;
            4'h8:      o_seg = SEG_8;
            4'h9:      o_seg = SEG_9;
            CODE_DASH: o_seg = SEG_DASH;
            CODE_F:    o_seg = SEG_F;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned update.
// Ports: clk, reset (sync, high), char_in/load (staging), busy,
// frame_start (frame pulse), an (digit enables), LED (segments).
module led_scan_driver
    import led_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int GAP_CYCLES       = 16,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] char_in,
    input  logic                    load,
    output logic                    busy,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              LED
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0]   AN_OFF    = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{CODE_BLANK}};

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] r_stage, r_disp;
    logic                    r_pend;
    logic                    r_frame;
    logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;
    logic [6:0]              r_led, w_led_nxt;

    logic                    w_show_end, w_gap_end, w_slot_end, w_wrap;
    logic [3:0]              w_code;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_show_end  = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
        w_gap_end   = (r_state == ST_GAP) && (r_cnt == GAP_LAST);
        // Without a gap the slot ends as soon as the lit phase ends.
        w_slot_end  = (GAP_CYCLES == 0) ? w_show_end : w_gap_end;
        w_wrap      = w_slot_end && (r_idx == IDX_LAST);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        if (w_show_end || w_gap_end)
            w_cnt_nxt = '0;
        if (w_show_end && GAP_CYCLES != 0)
            w_state_nxt = ST_GAP;
        if (w_gap_end)
            w_state_nxt = ST_SHOW;
        if (w_slot_end)
            w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
    end

    assign w_code = r_disp[{r_idx, 2'b00} +: 4];

    seg7_decode u_dec (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // Output logic
    always_comb begin
        w_sel     = '0;
        w_led_nxt = SEG_BLANK;
        if (r_state == ST_SHOW) begin
            w_sel     = NUM_DIGITS'(1) << r_idx;
            w_led_nxt = w_seg;
        end
        w_an_nxt = ANODE_ACTIVE_LOW ? ~w_sel : w_sel;
    end

    // Staging and display data; display only changes at the wrap,
    // and a coincident load is staged behind the value being committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= ALL_BLANK;
            r_disp  <= ALL_BLANK;
            r_pend  <= 1'b0;
        end else begin
            if (w_wrap)
                r_disp <= r_stage;
            if (load)
                r_stage <= char_in;
            if (load)
                r_pend <= 1'b1;
            else if (w_wrap)
                r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an    <= AN_OFF;
            r_led   <= SEG_BLANK;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_nxt;
            r_led   <= w_led_nxt;
            r_frame <= w_wrap;
        end
    end

    assign an          = r_an;
    assign LED         = r_led;
    assign frame_start = r_frame;
    assign busy        = r_pend;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver (4 digits, 4-cycle slots, 1-cycle gap).
// Frame timeline: frame_start seen at f, digit k lit at f+1+5k .. f+4+5k.
module tb_led_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] char_in = '0;
    logic        busy;
    logic        frame_start;
    logic [3:0]  an;
    logic [6:0]  LED;

    int checks = 0;
    int errors = 0;

    logic [3:0] cap_an  [1:20];
    logic [6:0] cap_led [1:20];

    led_scan_driver #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .GAP_CYCLES       (1),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .load        (load),
        .busy        (busy),
        .frame_start (frame_start),
        .an          (an),
        .LED         (LED)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic capture();
        for (int i = 1; i <= 20; i++) begin
            tick();
            cap_an[i]  = an;
            cap_led[i] = LED;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL reset_an got %b want 1111", an);
        end
        checks++;
        if (LED !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_led got %b want 1111111", LED);
        end
        checks++;
        if (busy !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b fs=%b want 0 0", busy, frame_start);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (an !== 4'b1110 || LED !== 7'b1111111) begin
            errors++;
            $display("FAIL first_slot got an=%b led=%b want 1110 1111111", an, LED);
        end
    endtask

    task automatic test_frame_period();
        int n;
        wait_frame(n);
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL first_frame got %0d cycles want 19", n);
        end
        tick();
        wait_frame(n);
        checks++;
        if (n + 1 != 20) begin
            errors++;
            $display("FAIL frame_period got %0d want 20", n + 1);
        end
    endtask

    task automatic test_gap();
        logic [3:0] e;
        int bad;
        capture();
        for (int k = 0; k < 4; k++) begin
            e = ~(4'b0001 << k);
            bad = 0;
            for (int j = 1; j <= 4; j++)
                if (cap_an[5*k+j] !== e || cap_led[5*k+j] !== 7'h7f) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL slot%0d_lit got an=%b want %b for 4 cycles", k, cap_an[5*k+1], e);
            end
            checks++;
            if (cap_an[5*k+5] !== 4'b1111 || cap_led[5*k+5] !== 7'h7f) begin
                errors++;
                $display("FAIL gap%0d got an=%b led=%b want 1111 1111111", k, cap_an[5*k+5], cap_led[5*k+5]);
            end
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL gap_frame_pulse got %b want 1", frame_start);
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] exp [4];
        int n;
        int bad;
        exp = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        repeat (3) tick();
        char_in = 16'h4321;
        load = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        bad = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            if (LED !== 7'h7f || busy !== 1'b1) bad++;
            tick();
            n++;
        end
        checks++;
        if (n >= 40 || bad != 0) begin
            errors++;
            $display("FAIL mid_hold got %0d bad cycles n=%0d want 0", bad, n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_clear got %b want 0", busy);
        end
        capture();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_led[5*k+1] !== exp[k]) begin
                errors++;
                $display("FAIL mid_digit%0d got %b want %b", k, cap_led[5*k+1], exp[k]);
            end
        end
    endtask

    task automatic test_two_loads();
        logic [6:0] exp [4];
        int n;
        int bad;
        exp = '{7'b0000000, 7'b0000100, 7'b1111110, 7'b0111000};
        repeat (2) tick();
        char_in = 16'h1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        char_in = 16'hBA98;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL two_busy got %b want 1", busy);
        end
        wait_frame(n);
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL two_frame_timeout got %0d want <40", n);
        end
        capture();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_led[5*k+1] !== exp[k]) begin
                errors++;
                $display("FAIL two_digit%0d got %b want %b", k, cap_led[5*k+1], exp[k]);
            end
        end
        for (int i = 1; i <= 20; i++)
            if (cap_led[i] === 7'b1001111) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL two_no_ones got %0d cycles of 1 want 0", bad);
        end
    endtask

    task automatic test_load_at_wrap();
        logic [6:0] exp [4];
        int bad;
        exp = '{7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
        repeat (2) tick();
        char_in = 16'h0123;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (16) tick();
        char_in = 16'h5555;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load got fs=%b busy=%b want 1 1", frame_start, busy);
        end
        capture();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_led[5*k+1] !== exp[k]) begin
                errors++;
                $display("FAIL wrap_old_digit%0d got %b want %b", k, cap_led[5*k+1], exp[k]);
            end
        end
        checks++;
        if (frame_start !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_commit2 got fs=%b busy=%b want 1 0", frame_start, busy);
        end
        capture();
        bad = 0;
        for (int k = 0; k < 4; k++)
            if (cap_led[5*k+1] !== 7'b0100100) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_new got %0d wrong digits want 0 (5555)", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        tick();
        char_in = 16'h8888;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        checks++;
        if (an !== 4'b1011 || LED !== 7'b0100100) begin
            errors++;
            $display("FAIL rst_pre got an=%b led=%b want 1011 0100100", an, LED);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (an !== 4'b1111 || LED !== 7'h7f || busy !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got an=%b led=%b busy=%b fs=%b want 1111 1111111 0 0",
                     an, LED, busy, frame_start);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (an !== 4'b1110 || LED !== 7'h7f) begin
            errors++;
            $display("FAIL rst_release got an=%b led=%b want 1110 1111111", an, LED);
        end
        wait_frame(n);
        capture();
        bad = 0;
        for (int i = 1; i <= 20; i++)
            if (cap_led[i] !== 7'h7f) bad++;
        checks++;
        if (n >= 40 || bad != 0) begin
            errors++;
            $display("FAIL rst_blank got %0d lit cycles n=%0d want 0", bad, n);
        end
    endtask

    initial begin
        test_reset();
        test_frame_period();
        test_gap();
        test_load_midframe();
        test_two_loads();
        test_load_at_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
